// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode, execute, memory and
// writeback over a shared-memory datapath, with a variable-latency memory handshake, a wait
// timeout and a sticky error state.
// Optional feature macro: MIPS_MC_BNE_EN adds bne (op 000101), executed through BEQEX.
module mips_mc_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StRst    = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StRtEx   = 4'd7,
        StRtWb   = 4'd8,
        StBeqEx  = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StJEx    = 4'd12,
        StErr    = 4'd13
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // Wraps harmlessly when TIMEOUT_CYC is 0; the comparison is disabled in that case.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Remembers lw/sw from DECODE so MEMADR does not need op again.
    logic             is_sw_q, is_sw_d;
`ifdef MIPS_MC_BNE_EN
    logic             is_bne_q, is_bne_d;
`endif
    logic             funct_ok;
    logic             timeout_hit;
    logic             waiting;

    // Supported R-type functions and wait-state timeout detection.
    always_comb begin
        funct_ok    = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                      (funct == FnOr)  || (funct == FnSlt);
        waiting     = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
        timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TimeoutLast) && !mem_ready;
    end

    // State register, timeout counter and decode-time instruction flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StRst;
            cnt_q    <= '0;
            is_sw_q  <= 1'b0;
`ifdef MIPS_MC_BNE_EN
            is_bne_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_sw_q  <= is_sw_d;
`ifdef MIPS_MC_BNE_EN
            is_bne_q <= is_bne_d;
`endif
        end
    end

    // Next-state logic; memory waits fall into ERR once the timeout expires.
    always_comb begin
        state_d  = state_q;
        is_sw_d  = is_sw_q;
`ifdef MIPS_MC_BNE_EN
        is_bne_d = is_bne_q;
`endif
        unique case (state_q)
            StRst:   state_d = StFetch;
            StFetch: begin
                if (mem_ready)        state_d = StDecode;
                else if (timeout_hit) state_d = StErr;
            end
            StDecode: begin
                is_sw_d = (op == OpSw);
`ifdef MIPS_MC_BNE_EN
                is_bne_d = (op == OpBne);
`endif
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = funct_ok ? StRtEx : StErr;
                    OpBeq:      state_d = StBeqEx;
`ifdef MIPS_MC_BNE_EN
                    OpBne:      state_d = StBeqEx;
`endif
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default:    state_d = StErr;
                endcase
            end
            StMemAdr: state_d = is_sw_q ? StMemWr : StMemRd;
            StMemRd: begin
                if (mem_ready)        state_d = StMemWb;
                else if (timeout_hit) state_d = StErr;
            end
            StMemWr: begin
                if (mem_ready)        state_d = StFetch;
                else if (timeout_hit) state_d = StErr;
            end
            StMemWb, StRtWb, StBeqEx, StAddiWb, StJEx: state_d = StFetch;
            StRtEx:   state_d = StRtWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StErr;
        endcase

        // Counter restarts on any state change, counts only not-ready wait cycles.
        cnt_d = cnt_q;
        if (state_d != state_q)        cnt_d = '0;
        else if (waiting && !mem_ready) cnt_d = cnt_q + CNT_W'(1);
    end

    // Moore outputs per state; pcen/irwrite in FETCH and pcen in BEQEX also see the inputs.
    always_comb begin
        pcen       = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        err        = 1'b0;
        unique case (state_q)
            StFetch: begin
                memread    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                pcen       = mem_ready;
                irwrite    = mem_ready;
            end
            StDecode: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            StMemAdr, StAddiEx: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            StMemRd: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtEx: begin
                alusrca = 1'b1;
                case (funct)
                    FnAdd:   alucontrol = 3'b010;
                    FnSub:   alucontrol = 3'b110;
                    FnAnd:   alucontrol = 3'b000;
                    FnOr:    alucontrol = 3'b001;
                    FnSlt:   alucontrol = 3'b111;
                    default: alucontrol = 3'b000;
                endcase
            end
            StRtWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
`ifdef MIPS_MC_BNE_EN
                pcen       = is_bne_q ? ~zero : zero;
`else
                pcen       = zero;
`endif
            end
            StAddiWb: regwrite = 1'b1;
            StJEx: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            StErr:   err = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: reset, each instruction class, wait states, timeout,
// illegal decode and the optional bne feature (MIPS_MC_BNE_EN).
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       err;
    logic [3:0] state;
    logic [16:0] outs;

    int total = 0;
    int passed = 0;

    // {pcen,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluc,err}
    localparam logic [16:0] O_NONE = 17'b0_0_0_0_0_0_0_0_0_00_00_000_0;
    localparam logic [16:0] O_F1   = 17'b1_0_1_0_1_0_0_0_0_01_00_010_0;
    localparam logic [16:0] O_F0   = 17'b0_0_1_0_0_0_0_0_0_01_00_010_0;
    localparam logic [16:0] O_DEC  = 17'b0_0_0_0_0_0_0_0_0_11_00_010_0;
    localparam logic [16:0] O_MADR = 17'b0_0_0_0_0_0_0_0_1_10_00_010_0;
    localparam logic [16:0] O_MRD  = 17'b0_1_1_0_0_0_0_0_0_00_00_000_0;
    localparam logic [16:0] O_MWB  = 17'b0_0_0_0_0_0_1_1_0_00_00_000_0;
    localparam logic [16:0] O_MWR  = 17'b0_1_0_1_0_0_0_0_0_00_00_000_0;
    localparam logic [16:0] O_RSUB = 17'b0_0_0_0_0_0_0_0_1_00_00_110_0;
    localparam logic [16:0] O_ROR  = 17'b0_0_0_0_0_0_0_0_1_00_00_001_0;
    localparam logic [16:0] O_RTWB = 17'b0_0_0_0_0_1_0_1_0_00_00_000_0;
    localparam logic [16:0] O_BR1  = 17'b1_0_0_0_0_0_0_0_1_00_01_110_0;
    localparam logic [16:0] O_BR0  = 17'b0_0_0_0_0_0_0_0_1_00_01_110_0;
    localparam logic [16:0] O_AIEX = 17'b0_0_0_0_0_0_0_0_1_10_00_010_0;
    localparam logic [16:0] O_AIWB = 17'b0_0_0_0_0_0_0_1_0_00_00_000_0;
    localparam logic [16:0] O_JEX  = 17'b1_0_0_0_0_0_0_0_0_00_10_000_0;
    localparam logic [16:0] O_ERR  = 17'b0_0_0_0_0_0_0_0_0_00_00_000_1;

    mips_mc_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .err(err), .state(state)
    );

    assign outs = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, pcsrc, alucontrol, err};

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (state !== 4'd0 || outs !== O_NONE)
                $display("FAIL reset cyc %0d: state=%0d outs=%b, want state=0 outs=%b",
                         i, state, outs, O_NONE);
            else passed++;
        end
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0) $display("FAIL reset_release: state=%0d, want 0", state);
        else passed++;
        tick();
        total++;
        if (state !== 4'd1 || outs !== O_F1)
            $display("FAIL reset_to_fetch: state=%0d outs=%b, want state=1 outs=%b",
                     state, outs, O_F1);
        else passed++;
    endtask

    task automatic test_lw();
        logic [3:0]  st [6];
        logic [16:0] ex [6];
        st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        ex = '{O_F1, O_DEC, O_MADR, O_MRD, O_MWB, O_F1};
        op = 6'b100011;
        zero = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (state !== st[i] || outs !== ex[i])
                $display("FAIL lw step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, st[i], ex[i]);
            else passed++;
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  st [8];
        logic [16:0] ex [8];
        logic        mr [8];
        st = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6, 4'd6, 4'd1};
        ex = '{O_F1, O_DEC, O_MADR, O_MWR, O_MWR, O_MWR, O_MWR, O_F1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== st[i] || outs !== ex[i])
                $display("FAIL sw_wait step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, st[i], ex[i]);
            else passed++;
            if (i < 7) tick();
        end
    endtask

    task automatic test_beq();
        logic [3:0]  st [7];
        logic [16:0] ex [7];
        logic        zs [7];
        st = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
        ex = '{O_F1, O_DEC, O_BR1, O_F1, O_DEC, O_BR0, O_F1};
        zs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        op = 6'b000100;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            zero = zs[i];
            #1;
            total++;
            if (state !== st[i] || outs !== ex[i])
                $display("FAIL beq step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, st[i], ex[i]);
            else passed++;
            if (i < 6) tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0]  st [9];
        logic [16:0] ex [9];
        logic [5:0]  fn [9];
        st = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        ex = '{O_F1, O_DEC, O_RSUB, O_RTWB, O_F1, O_DEC, O_ROR, O_RTWB, O_F1};
        fn = '{6'b100010, 6'b100010, 6'b100010, 6'b100010,
               6'b100101, 6'b100101, 6'b100101, 6'b100101, 6'b100101};
        op = 6'b000000;
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            funct = fn[i];
            #1;
            total++;
            if (state !== st[i] || outs !== ex[i])
                $display("FAIL rtype step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, st[i], ex[i]);
            else passed++;
            if (i < 8) tick();
        end
    endtask

    task automatic test_addi_j();
        logic [3:0]  st [8];
        logic [16:0] ex [8];
        logic [5:0]  ops [8];
        st = '{4'd1, 4'd2, 4'd10, 4'd11, 4'd1, 4'd2, 4'd12, 4'd1};
        ex = '{O_F1, O_DEC, O_AIEX, O_AIWB, O_F1, O_DEC, O_JEX, O_F1};
        ops = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
                6'b000010, 6'b000010, 6'b000010, 6'b000010};
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = ops[i];
            #1;
            total++;
            if (state !== st[i] || outs !== ex[i])
                $display("FAIL addi_j step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, st[i], ex[i]);
            else passed++;
            if (i < 7) tick();
        end
    endtask

    task automatic test_timeout();
        // 15 not-ready cycles, then ready in the 16th: ready wins, no error.
        op = 6'b000010;
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            total++;
            if (state !== 4'd1 || outs !== O_F0)
                $display("FAIL wait_fetch cyc %0d: state=%0d outs=%b, want state=1 outs=%b",
                         i, state, outs, O_F0);
            else passed++;
            tick();
        end
        mem_ready = 1'b1;
        tick();
        total++;
        if (state !== 4'd2) $display("FAIL ready_wins: state=%0d, want 2", state);
        else passed++;
        tick();
        tick();
        // 16 not-ready cycles in FETCH: timeout to ERR.
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++;
            if (state !== 4'd1)
                $display("FAIL timeout_fetch cyc %0d: state=%0d, want 1", i, state);
            else passed++;
            tick();
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== 4'd13 || outs !== O_ERR)
                $display("FAIL timeout_err cyc %0d: state=%0d outs=%b, want state=13 outs=%b",
                         i, state, outs, O_ERR);
            else passed++;
            tick();
        end
        do_reset();
        total++;
        if (state !== 4'd1 || err !== 1'b0)
            $display("FAIL err_cleared: state=%0d err=%b, want state=1 err=0", state, err);
        else passed++;
    endtask

    task automatic test_decode_err();
        mem_ready = 1'b1;
        op = 6'b111111;
        tick();
        tick();
        total++;
        if (state !== 4'd13 || outs !== O_ERR)
            $display("FAIL bad_op: state=%0d outs=%b, want state=13 outs=%b",
                     state, outs, O_ERR);
        else passed++;
        do_reset();
        op = 6'b000000;
        funct = 6'b111111;
        tick();
        tick();
        total++;
        if (state !== 4'd13 || err !== 1'b1)
            $display("FAIL bad_funct: state=%0d err=%b, want state=13 err=1", state, err);
        else passed++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        op = 6'b100011;
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || outs !== O_NONE)
            $display("FAIL reset_mid: state=%0d outs=%b, want state=0 outs=%b",
                     state, outs, O_NONE);
        else passed++;
        tick();
        total++;
        if (state !== 4'd0 || regwrite !== 1'b0)
            $display("FAIL reset_mid_hold: state=%0d regwrite=%b, want state=0 regwrite=0",
                     state, regwrite);
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if (state !== 4'd1) $display("FAIL reset_mid_fetch: state=%0d, want 1", state);
        else passed++;
    endtask

    task automatic test_bne();
`ifdef MIPS_MC_BNE_EN
        logic [3:0]  st [7];
        logic [16:0] ex [7];
        logic        zs [7];
        st = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
        ex = '{O_F1, O_DEC, O_BR1, O_F1, O_DEC, O_BR0, O_F1};
        zs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 6'b000101;
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            zero = zs[i];
            #1;
            total++;
            if (state !== st[i] || outs !== ex[i])
                $display("FAIL bne step %0d: state=%0d outs=%b, want state=%0d outs=%b",
                         i, state, outs, st[i], ex[i]);
            else passed++;
            if (i < 6) tick();
        end
        zero = 1'b0;
`else
        op = 6'b000101;
        mem_ready = 1'b1;
        tick();
        tick();
        total++;
        if (state !== 4'd13 || err !== 1'b1)
            $display("FAIL bne_disabled: state=%0d err=%b, want state=13 err=1", state, err);
        else passed++;
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype();
        test_addi_j();
        test_timeout();
        test_decode_err();
        test_reset_mid();
        test_bne();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
